// File: rtl/dma_arb_pkg.sv
// Shared types and default sizing for the DMA channel arbiter.
package dma_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_GRANT   = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_CH         = 4;
    localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/dma_channel_arbiter_if.sv
// Request/grant signal bundle between the DMA channels, the CPU hold handshake and the arbiter.
interface dma_channel_arbiter_if #(
    parameter int NUM_CH = 4
);
    localparam int ID_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0] dreq;
    logic [NUM_CH-1:0] sw_req;
    logic [NUM_CH-1:0] mask;
    logic              rotating_priority;
    logic              sense_dreq;
    logic              sense_dack;
    logic              dma_disable;
    logic              hlda;
    logic              hrq;
    logic [NUM_CH-1:0] dack;
    logic [ID_W-1:0]   req_id;
    logic              valid_req_id;
    logic [NUM_CH-1:0] pending_req;
    logic              timeout;

    modport master (
        output dreq, sw_req, mask, rotating_priority, sense_dreq, sense_dack, dma_disable, hlda,
        input  hrq, dack, req_id, valid_req_id, pending_req, timeout
    );

    modport slave (
        input  dreq, sw_req, mask, rotating_priority, sense_dreq, sense_dack, dma_disable, hlda,
        output hrq, dack, req_id, valid_req_id, pending_req, timeout
    );

endinterface

// File: rtl/dma_rr_pick.sv
// Combinational winner select: lowest index in fixed mode, round-robin after the last grant in rotating mode.
module dma_rr_pick #(
    parameter int  NUM_CH = 4,
    localparam int ID_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_valid_req,
    input  logic [ID_W-1:0]   i_least_priority,
    input  logic              i_rotating_priority,
    output logic [ID_W-1:0]   o_winner
);

    logic [ID_W-1:0] w_base;
    logic [ID_W-1:0] w_idx;

    always_comb begin
        w_base   = i_rotating_priority ? i_least_priority + ID_W'(1) : '0;
        w_idx    = '0;
        o_winner = '0;
        // Walk from the farthest candidate back to w_base so the nearest valid channel is written last;
        // the index wraps for free because NUM_CH is a power of two.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_idx = w_base + ID_W'(k);
            if (i_valid_req[w_idx]) o_winner = w_idx;
        end
    end

endmodule

// File: rtl/dma_channel_arbiter.sv
// DMA channel arbiter: qualifies requests, runs the Hrq/Hlda handshake and decodes Dack.
// Define ARB_HLDA_TIMEOUT_EN to abort a request whose Hlda does not arrive within TIMEOUT_CYCLES.
module dma_channel_arbiter
    import dma_arb_pkg::*;
#(
    parameter int  NUM_CH         = DEF_NUM_CH,
    parameter int  TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int ID_W           = $clog2(NUM_CH)
) (
    input logic                  i_clock,
    input logic                  i_reset,
    dma_channel_arbiter_if.slave bus
);

    arb_state_e        r_state;
    arb_state_e        w_next_state;
    logic [ID_W-1:0]   r_req_id;
    logic [ID_W-1:0]   r_least_pri;
    logic [ID_W-1:0]   w_winner;
    logic [NUM_CH-1:0] r_pending;
    logic [NUM_CH-1:0] w_valid_req;
    logic [NUM_CH-1:0] w_onehot;
    logic              w_start;
    logic              w_grant_active;
    logic              w_expire;

    assign w_valid_req = ((bus.dreq ^ {NUM_CH{bus.sense_dreq}}) | bus.sw_req) & ~bus.mask;
    assign w_start     = (|w_valid_req) & ~bus.hlda & ~bus.dma_disable & ~i_reset;

    dma_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
        .i_valid_req         (w_valid_req),
        .i_least_priority    (r_least_pri),
        .i_rotating_priority (bus.rotating_priority),
        .o_winner            (w_winner)
    );

`ifdef ARB_HLDA_TIMEOUT_EN
    logic [15:0] r_to_cnt;
    logic        r_timeout;

    assign w_expire = (r_state == ST_REQUEST) && !bus.hlda && (r_to_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_expire;
            if (r_state == ST_IDLE && w_start)
                r_to_cnt <= '0;
            else if (r_state == ST_REQUEST && !bus.hlda)
                r_to_cnt <= r_to_cnt + 16'd1;
        end
    end

    assign bus.timeout = r_timeout;
`else
    assign w_expire    = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values,
    // independent of the order the simulator runs these processes.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_req_id    <= '0;
            r_least_pri <= ID_W'(NUM_CH - 1);
            r_pending   <= '0;
        end else begin
            r_state   <= w_next_state;
            r_pending <= w_valid_req;
            if (r_state == ST_IDLE && w_start)
                r_req_id <= w_winner;
            // A timed-out request never reaches this load, so rotation only advances on real grants.
            if (r_state == ST_REQUEST && bus.hlda && bus.rotating_priority)
                r_least_pri <= r_req_id;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state     = r_state;
        bus.hrq          = 1'b0;
        bus.valid_req_id = 1'b0;
        w_grant_active   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.valid_req_id = w_start;
                if (w_start) w_next_state = ST_REQUEST;
            end
            ST_REQUEST: begin
                bus.hrq          = 1'b1;
                bus.valid_req_id = 1'b1;
                w_grant_active   = bus.hlda;
                if (bus.hlda)
                    w_next_state = ST_GRANT;
                else if (w_expire)
                    w_next_state = ST_IDLE;
            end
            ST_GRANT: begin
                bus.hrq          = bus.hlda;
                bus.valid_req_id = bus.hlda;
                w_grant_active   = bus.hlda;
                if (!bus.hlda) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
        if (i_reset) begin
            bus.hrq          = 1'b0;
            bus.valid_req_id = 1'b0;
            w_grant_active   = 1'b0;
        end
    end

    assign w_onehot        = w_grant_active ? (NUM_CH'(1) << r_req_id) : '0;
    assign bus.dack        = bus.sense_dack ? w_onehot : ~w_onehot;
    assign bus.req_id      = r_req_id;
    assign bus.pending_req = r_pending;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Bench for dma_channel_arbiter: directed scenarios followed by randomized traffic against a protocol-level model.
module tb_dma_channel_arbiter;

    localparam int N     = 8;
    localparam int ID_W  = $clog2(N);
    localparam int TB_TO = 4;

    logic clk     = 1'b0;
    logic i_reset = 1'b1;
    int   n_vec   = 0;
    int   n_err   = 0;

    always #5 clk = ~clk;

    dma_channel_arbiter_if #(.NUM_CH(N)) bus ();

    dma_channel_arbiter #(.NUM_CH(N), .TIMEOUT_CYCLES(TB_TO)) dut (
        .i_clock (clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    // Model of the grant protocol: phase 0 = no hold wanted, 1 = waiting for Hlda, 2 = bus held.
    int           m_phase   = 0;
    int           m_id      = 0;
    int           m_lp      = N - 1;
    int           m_wait    = 0;
    logic [N-1:0] m_pending = '0;
    bit           m_to      = 1'b0;

    function automatic logic [N-1:0] ref_valid();
        return ((bus.dreq ^ {N{bus.sense_dreq}}) | bus.sw_req) & ~bus.mask;
    endfunction

    function automatic int ref_pick(logic [N-1:0] v, bit rot, int lp);
        for (int off = 1; off <= N; off++) begin
            int ch;
            ch = rot ? (lp + off) % N : off - 1;
            if (v[ch]) return ch;
        end
        return 0;
    endfunction

    always @(posedge clk) begin
        if (i_reset) begin
            m_phase <= 0; m_id <= 0; m_lp <= N - 1; m_pending <= '0; m_wait <= 0; m_to <= 1'b0;
        end else begin
            m_pending <= ref_valid();
            m_to      <= 1'b0;
            if (m_phase == 0) begin
                if (ref_valid() != '0 && !bus.hlda && !bus.dma_disable) begin
                    m_id    <= ref_pick(ref_valid(), bus.rotating_priority, m_lp);
                    m_phase <= 1;
                    m_wait  <= 0;
                end
            end else if (m_phase == 1) begin
                if (bus.hlda) begin
                    m_phase <= 2;
                    if (bus.rotating_priority) m_lp <= m_id;
                end
`ifdef ARB_HLDA_TIMEOUT_EN
                else begin
                    m_wait <= m_wait + 1;
                    if (m_wait + 1 == TB_TO) begin
                        m_phase <= 0;
                        m_to    <= 1'b1;
                    end
                end
`endif
            end else if (!bus.hlda) begin
                m_phase <= 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_defaults();
        bus.dreq = '0; bus.sw_req = '0; bus.mask = '0; bus.rotating_priority = 1'b0;
        bus.sense_dreq = 1'b0; bus.sense_dack = 1'b1; bus.dma_disable = 1'b0; bus.hlda = 1'b0;
    endtask

    task automatic do_reset();
        set_defaults();
        i_reset = 1'b1;
        tick(); tick();
        i_reset = 1'b0;
    endtask

    task automatic release_bus();
        bus.hlda = 1'b0; bus.sense_dreq = 1'b0; bus.dreq = '0; bus.sw_req = '0; bus.mask = '0;
        tick(); tick();
    endtask

    task automatic test_reset();
        set_defaults();
        bus.dreq = 8'h0F;
        i_reset  = 1'b1;
        tick(); tick();
        @(negedge clk);
        n_vec++; if (bus.hrq !== 1'b0) begin n_err++; $display("FAIL reset_hrq: got %0b expected 0", bus.hrq); end
        n_vec++; if (bus.valid_req_id !== 1'b0) begin n_err++; $display("FAIL reset_vrid: got %0b expected 0", bus.valid_req_id); end
        n_vec++; if (bus.dack !== 8'h00) begin n_err++; $display("FAIL reset_dack: got %0h expected 00", bus.dack); end
        n_vec++; if (bus.req_id !== 3'd0) begin n_err++; $display("FAIL reset_req_id: got %0d expected 0", bus.req_id); end
        n_vec++; if (bus.pending_req !== 8'h00) begin n_err++; $display("FAIL reset_pending: got %0h expected 00", bus.pending_req); end
        n_vec++; if (bus.timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %0b expected 0", bus.timeout); end
        tick();
        i_reset  = 1'b0;
        bus.dreq = '0;
        tick();
    endtask

    task automatic test_fixed();
        do_reset();
        bus.dreq = 8'b0000_1010;
        @(negedge clk);
        n_vec++; if (bus.valid_req_id !== 1'b1) begin n_err++; $display("FAIL fixed_vrid_idle: got %0b expected 1", bus.valid_req_id); end
        n_vec++; if (bus.hrq !== 1'b0) begin n_err++; $display("FAIL fixed_hrq_idle: got %0b expected 0", bus.hrq); end
        tick();
        bus.dreq = 8'b0000_0001;
        @(negedge clk);
        n_vec++; if (bus.req_id !== 3'd1) begin n_err++; $display("FAIL fixed_req_id: got %0d expected 1", bus.req_id); end
        n_vec++; if (bus.hrq !== 1'b1) begin n_err++; $display("FAIL fixed_hrq_req: got %0b expected 1", bus.hrq); end
        n_vec++; if (bus.dack !== 8'h00) begin n_err++; $display("FAIL fixed_dack_wait: got %0h expected 00", bus.dack); end
        tick(); tick();
        bus.hlda = 1'b1;
        @(negedge clk);
        n_vec++; if (bus.dack !== 8'h02) begin n_err++; $display("FAIL fixed_dack_rise: got %0h expected 02", bus.dack); end
        n_vec++; if (bus.req_id !== 3'd1) begin n_err++; $display("FAIL fixed_id_hold: got %0d expected 1", bus.req_id); end
        tick(); tick();
        bus.hlda = 1'b0;
        bus.dreq = '0;
        @(negedge clk);
        n_vec++; if (bus.dack !== 8'h00) begin n_err++; $display("FAIL fixed_dack_fall: got %0h expected 00", bus.dack); end
        n_vec++; if (bus.hrq !== 1'b0) begin n_err++; $display("FAIL fixed_hrq_fall: got %0b expected 0", bus.hrq); end
        release_bus();
    endtask

    task automatic test_rotating();
        do_reset();
        bus.rotating_priority = 1'b1;
        bus.dreq = 8'b0010_0000;
        tick();
        @(negedge clk);
        n_vec++; if (bus.req_id !== 3'd5) begin n_err++; $display("FAIL rot_first_id: got %0d expected 5", bus.req_id); end
        tick();
        bus.hlda = 1'b1;
        tick();
        bus.hlda = 1'b0;
        bus.dreq = '0;
        tick();
        bus.dreq = 8'b0010_0101;
        tick();
        @(negedge clk);
        n_vec++; if (bus.req_id !== 3'd0) begin n_err++; $display("FAIL rot_wrap_id: got %0d expected 0", bus.req_id); end
        tick();
        bus.hlda = 1'b1;
        tick();
        bus.hlda = 1'b0;
        tick(); tick();
        @(negedge clk);
        n_vec++; if (bus.req_id !== 3'd2) begin n_err++; $display("FAIL rot_lp_loaded: got %0d expected 2", bus.req_id); end
        tick();
        bus.hlda = 1'b1;
        tick();
        release_bus();
    endtask

    task automatic test_mask_polarity();
        do_reset();
        bus.sense_dreq = 1'b1;
        bus.sense_dack = 1'b0;
        bus.dreq = 8'hFE;
        bus.mask = 8'h02;
        @(negedge clk);
        n_vec++; if (bus.dack !== 8'hFF) begin n_err++; $display("FAIL pol_dack_idle: got %0h expected ff", bus.dack); end
        tick();
        @(negedge clk);
        n_vec++; if (bus.req_id !== 3'd0) begin n_err++; $display("FAIL pol_req_id: got %0d expected 0", bus.req_id); end
        n_vec++; if (bus.pending_req !== 8'h01) begin n_err++; $display("FAIL pol_pending: got %0h expected 01", bus.pending_req); end
        tick();
        bus.hlda = 1'b1;
        @(negedge clk);
        n_vec++; if (bus.dack !== 8'hFE) begin n_err++; $display("FAIL pol_dack_grant: got %0h expected fe", bus.dack); end
        tick();
        release_bus();
        bus.sense_dack = 1'b1;
        bus.dreq = 8'h07;
        bus.mask = 8'h03;
        tick();
        @(negedge clk);
        n_vec++; if (bus.req_id !== 3'd2) begin n_err++; $display("FAIL mask_skips_low: got %0d expected 2", bus.req_id); end
        tick();
        bus.hlda = 1'b1;
        tick();
        release_bus();
    endtask

    task automatic test_sw_disable();
        do_reset();
        bus.sw_req = 8'h04;
        bus.dma_disable = 1'b1;
        tick(); tick();
        @(negedge clk);
        n_vec++; if (bus.hrq !== 1'b0) begin n_err++; $display("FAIL dis_hrq: got %0b expected 0", bus.hrq); end
        n_vec++; if (bus.valid_req_id !== 1'b0) begin n_err++; $display("FAIL dis_vrid: got %0b expected 0", bus.valid_req_id); end
        n_vec++; if (bus.pending_req !== 8'h04) begin n_err++; $display("FAIL dis_pending: got %0h expected 04", bus.pending_req); end
        tick();
        bus.dma_disable = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.valid_req_id !== 1'b1) begin n_err++; $display("FAIL sw_vrid: got %0b expected 1", bus.valid_req_id); end
        tick();
        @(negedge clk);
        n_vec++; if (bus.req_id !== 3'd2) begin n_err++; $display("FAIL sw_req_id: got %0d expected 2", bus.req_id); end
        n_vec++; if (bus.hrq !== 1'b1) begin n_err++; $display("FAIL sw_hrq: got %0b expected 1", bus.hrq); end
        tick();
        bus.hlda = 1'b1;
        tick();
        release_bus();
    endtask

    task automatic test_timeout();
        do_reset();
        bus.rotating_priority = 1'b1;
        bus.dreq = 8'h08;
        tick();
        bus.dreq = '0;
`ifdef ARB_HLDA_TIMEOUT_EN
        for (int k = 0; k < TB_TO; k++) begin
            @(negedge clk);
            n_vec++; if (bus.hrq !== 1'b1) begin n_err++; $display("FAIL to_hrq_wait[%0d]: got %0b expected 1", k, bus.hrq); end
            n_vec++; if (bus.timeout !== 1'b0) begin n_err++; $display("FAIL to_early[%0d]: got %0b expected 0", k, bus.timeout); end
            tick();
        end
        @(negedge clk);
        n_vec++; if (bus.timeout !== 1'b1) begin n_err++; $display("FAIL to_pulse: got %0b expected 1", bus.timeout); end
        n_vec++; if (bus.hrq !== 1'b0) begin n_err++; $display("FAIL to_idle_hrq: got %0b expected 0", bus.hrq); end
        tick();
        @(negedge clk);
        n_vec++; if (bus.timeout !== 1'b0) begin n_err++; $display("FAIL to_one_cycle: got %0b expected 0", bus.timeout); end
        tick();
        bus.dreq = 8'h81;
        tick();
        @(negedge clk);
        n_vec++; if (bus.req_id !== 3'd0) begin n_err++; $display("FAIL to_lp_kept: got %0d expected 0", bus.req_id); end
        tick();
`else
        for (int k = 0; k < 5 * TB_TO; k++) begin
            @(negedge clk);
            n_vec++; if (bus.hrq !== 1'b1) begin n_err++; $display("FAIL nto_hrq_wait[%0d]: got %0b expected 1", k, bus.hrq); end
            n_vec++; if (bus.timeout !== 1'b0) begin n_err++; $display("FAIL nto_timeout[%0d]: got %0b expected 0", k, bus.timeout); end
            tick();
        end
`endif
        bus.hlda = 1'b1;
        tick();
        release_bus();
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        bus.dreq = 8'h40;
        tick();
        bus.hlda = 1'b1;
        tick();
        @(negedge clk);
        n_vec++; if (bus.dack !== 8'h40) begin n_err++; $display("FAIL rmg_dack_held: got %0h expected 40", bus.dack); end
        tick();
        i_reset = 1'b1;
        @(negedge clk);
        n_vec++; if (bus.dack !== 8'h00) begin n_err++; $display("FAIL rmg_dack: got %0h expected 00", bus.dack); end
        n_vec++; if (bus.hrq !== 1'b0) begin n_err++; $display("FAIL rmg_hrq: got %0b expected 0", bus.hrq); end
        n_vec++; if (bus.valid_req_id !== 1'b0) begin n_err++; $display("FAIL rmg_vrid: got %0b expected 0", bus.valid_req_id); end
        tick();
        @(negedge clk);
        n_vec++; if (bus.req_id !== 3'd0) begin n_err++; $display("FAIL rmg_req_id: got %0d expected 0", bus.req_id); end
        n_vec++; if (bus.pending_req !== 8'h00) begin n_err++; $display("FAIL rmg_pending: got %0h expected 00", bus.pending_req); end
        tick();
        i_reset = 1'b0;
        release_bus();
    endtask

    task automatic test_random();
        logic [N-1:0] v;
        logic [N-1:0] oh;
        logic [N-1:0] exp_dack;
        bit           start;
        bit           exp_hrq;
        bit           exp_vrid;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            i_reset  = ($urandom_range(0, 63) == 0);
            bus.dreq = N'($urandom);
            bus.sw_req = N'($urandom & $urandom & $urandom);
            bus.mask = N'($urandom & $urandom);
            if ($urandom_range(0, 15) == 0) bus.sense_dreq = ~bus.sense_dreq;
            if ($urandom_range(0, 15) == 0) bus.sense_dack = ~bus.sense_dack;
            bus.rotating_priority = ($urandom_range(0, 3) != 0);
            bus.dma_disable = ($urandom_range(0, 5) == 0);
            case (m_phase)
                0:       bus.hlda = ($urandom_range(0, 7) == 0);
                1:       bus.hlda = ($urandom_range(0, 2) == 0);
                default: bus.hlda = ($urandom_range(0, 3) != 0);
            endcase
            @(negedge clk);
            v        = ref_valid();
            start    = (v != '0) && !bus.hlda && !bus.dma_disable && !i_reset;
            exp_hrq  = !i_reset && (m_phase == 1 || (m_phase == 2 && bus.hlda));
            exp_vrid = !i_reset && ((m_phase == 0 && start) || m_phase == 1 || (m_phase == 2 && bus.hlda));
            oh       = (!i_reset && m_phase != 0 && bus.hlda) ? (N'(1) << m_id) : '0;
            exp_dack = bus.sense_dack ? oh : ~oh;
            n_vec++; if (bus.hrq !== exp_hrq) begin n_err++; $display("FAIL rnd_hrq @%0d: got %0b expected %0b", c, bus.hrq, exp_hrq); end
            n_vec++; if (bus.valid_req_id !== exp_vrid) begin n_err++; $display("FAIL rnd_vrid @%0d: got %0b expected %0b", c, bus.valid_req_id, exp_vrid); end
            n_vec++; if (bus.dack !== exp_dack) begin n_err++; $display("FAIL rnd_dack @%0d: got %0h expected %0h", c, bus.dack, exp_dack); end
            n_vec++; if (bus.req_id !== ID_W'(m_id)) begin n_err++; $display("FAIL rnd_req_id @%0d: got %0d expected %0d", c, bus.req_id, m_id); end
            n_vec++; if (bus.pending_req !== m_pending) begin n_err++; $display("FAIL rnd_pending @%0d: got %0h expected %0h", c, bus.pending_req, m_pending); end
            n_vec++; if (bus.timeout !== m_to) begin n_err++; $display("FAIL rnd_timeout @%0d: got %0b expected %0b", c, bus.timeout, m_to); end
            tick();
        end
        i_reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_defaults();
        test_reset();
        test_fixed();
        test_rotating();
        test_mask_polarity();
        test_sw_disable();
        test_timeout();
        test_reset_mid_grant();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dma_channel_arbiter.md
DMA_CHANNEL_ARBITER -- requirements
Module: dma_channel_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, the channel count; a power of two in 2..16.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, the Hlda wait limit in cycles; range 1..65535.
REQ-003 SHALL derive ID_W = $clog2(NUM_CH).
REQ-004 SHALL have ports: Clock  in  1  single clock, all logic on rising edge; Reset  in  1  synchronous, active-high.
REQ-005 SHALL have ports: Dreq  in  NUM_CH  device requests, polarity per SenseDreq; SwReq  in  NUM_CH  software requests, always active-high.
REQ-006 SHALL have ports: Mask  in  NUM_CH  1 = channel ignored; RotatingPriority  in  1  0 fixed, 1 rotating; SenseDreq  in  1  1 = Dreq active-low; SenseDack  in  1  1 = Dack active-high; DMA_Disable  in  1  blocks new arbitration.
REQ-007 SHALL have ports: Hlda  in  1  hold acknowledge from CPU; Hrq  out  1  hold request; Dack  out  NUM_CH  acknowledges, polarity per SenseDack.
REQ-008 SHALL have ports: ReqID  out  ID_W  granted channel; ValidReqID  out  1  ReqID meaningful; PendingReq  out  NUM_CH  registered valid requests; Timeout  out  1  single-cycle abort pulse.

Function
REQ-009 SHALL compute ValidReq = ((Dreq XOR {NUM_CH{SenseDreq}}) OR SwReq) AND NOT Mask, combinationally.
REQ-010 SHALL implement a three-state FSM: IDLE, REQUEST, GRANT.
REQ-011 IDLE -> REQUEST SHALL occur when |ValidReq AND NOT Hlda AND NOT DMA_Disable AND NOT Reset; on that edge ReqID SHALL register the winning channel.
REQ-012 Fixed mode: the lowest-index valid channel SHALL win.
REQ-013 Rotating mode: search SHALL start at LeastPriority+1 and wrap modulo NUM_CH; LeastPriority itself is searched last.
REQ-014 REQUEST -> GRANT SHALL occur on the first cycle Hlda=1; on that edge, if RotatingPriority=1, LeastPriority SHALL load ReqID.
REQ-015 GRANT -> IDLE SHALL occur on the first cycle Hlda=0.
REQ-016 Hrq SHALL be 1 in REQUEST, and in GRANT while Hlda=1; it SHALL be 0 otherwise.
REQ-017 ValidReqID SHALL be combinational: 1 in IDLE when the REQ-011 condition holds, 1 in REQUEST, 1 in GRANT while Hlda=1, 0 otherwise.
REQ-018 The active one-hot at bit ReqID SHALL be driven when in (REQUEST or GRANT) and Hlda=1; it is therefore visible in the same cycle Hlda first rises and is removed in the same cycle Hlda falls.
REQ-019 Dack SHALL equal the one-hot when SenseDack=1 and its bitwise inverse when SenseDack=0; all channels SHALL be inactive when no grant is held.
REQ-020 PendingReq SHALL register ValidReq every cycle.
REQ-021 Changes to Mask, Dreq, SwReq or DMA_Disable during REQUEST or GRANT SHALL NOT alter ReqID or the FSM; DMA_Disable affects IDLE exit only.
REQ-022 If ValidReq=0 in IDLE, ReqID SHALL hold its previous value.

Reset
REQ-023 On Reset=1 at a rising edge: state IDLE, ReqID 0, LeastPriority NUM_CH-1, PendingReq 0, timeout counter 0, Timeout 0.
REQ-024 While Reset=1, ValidReqID and Hrq SHALL be 0 and Dack SHALL be inactive, including when Reset asserts in REQUEST or GRANT.

Configuration
REQ-025 Macro ARB_HLDA_TIMEOUT_EN SHALL select the timeout feature.
REQ-026 With ARB_HLDA_TIMEOUT_EN defined: a counter SHALL clear on entry to REQUEST and increment each REQUEST cycle with Hlda=0.
REQ-027 With ARB_HLDA_TIMEOUT_EN defined: when the count reaches TIMEOUT_CYCLES, the FSM SHALL return to IDLE, Timeout SHALL pulse for one cycle, and LeastPriority SHALL be unchanged.
REQ-028 Without ARB_HLDA_TIMEOUT_EN: there SHALL be no counter, Timeout SHALL be tied 0, and REQUEST SHALL wait indefinitely.

Structure
REQ-029 Package dma_arb_pkg SHALL hold the FSM state enum and the NUM_CH/TIMEOUT_CYCLES default constants.
REQ-030 Sub-module dma_rr_pick (combinational, parameter NUM_CH; inputs ValidReq, LeastPriority, RotatingPriority; output winner ID) SHALL implement REQ-012 and REQ-013.

Verification
REQ-031 Fixed, NUM_CH=4: Dreq=1010, Mask=0000, Hlda raised 2 cycles later -> ReqID=1, Dack=0010 (SenseDack=1) in the Hlda-rise cycle.
REQ-032 Rotating, NUM_CH=8: LeastPriority=5, ValidReq=00100101 -> ReqID=0; after Hlda rises, LeastPriority=0.
REQ-033 Masking and polarity: SenseDreq=1, Dreq=1110, Mask=0010 -> ReqID=0; SenseDack=0 -> Dack=1110 during grant.
REQ-034 Software request: Dreq=0000, SwReq=0100, DMA_Disable=1 -> FSM stays IDLE; DMA_Disable=0 -> ReqID=2, Hrq=1 next cycle.
REQ-035 Timeout with ARB_HLDA_TIMEOUT_EN, TIMEOUT_CYCLES=4: request, Hlda held 0 -> Timeout pulses after 4 REQUEST cycles, FSM returns to IDLE, LeastPriority unchanged.
REQ-036 Reset mid-GRANT: Reset=1 with Hlda=1 -> Dack inactive, Hrq=0, ReqID=0, PendingReq=0 after the edge.
